// File: rtl/multiword_cla_sequencer_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
// The optional CHAIN_EN macro is consumed by multiword_cla_sequencer.sv.
package multiword_cla_sequencer_pkg;

   localparam int unsigned SLICE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Slice index width; a single-slice build still needs a 1-bit counter.
   function automatic int unsigned idx_width(input int unsigned words);
      int unsigned w;
      w = $clog2(words);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/multiword_cla_sequencer_cla.sv
// 8-bit carry look-ahead adder: each carry is a flat sum-of-products of
// generate/propagate terms rather than a rippled chain.
module carry_look_ahead_adder
   import multiword_cla_sequencer_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               carry_in_i,
   output logic [SLICE_W-1:0] s_o,
   output logic               carry_out_o
);

   logic [SLICE_W-1:0] gen;
   logic [SLICE_W-1:0] prop;
   logic [SLICE_W:0]   carry;

   assign gen  = a_i & b_i;
   assign prop = a_i ^ b_i;

   // carry[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c0
   always_comb begin
      logic prod;
      // NOTE: every always_comb output is assigned a default before any branch so no latch is inferred.
      carry    = '0;
      carry[0] = carry_in_i;
      for (int i = 1; i <= SLICE_W; i++) begin
         prod = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            carry[i] = carry[i] | (gen[j] & prod);
            prod     = prod & prop[j];
         end
         carry[i] = carry[i] | (prod & carry_in_i);
      end
   end

   assign s_o         = prop ^ carry[SLICE_W-1:0];
   assign carry_out_o = carry[SLICE_W];

endmodule

// File: rtl/multiword_cla_sequencer.sv
// Multi-precision adder that streams WORDS byte slices, LSB first, through one 8-bit CLA.
// Define CHAIN_EN to add chain_in and a last_carry register for cross-transaction adds.
module multiword_cla_sequencer
   import multiword_cla_sequencer_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_valid,
   output logic                       start_ready,
   input  logic [SLICE_W*WORDS-1:0]   op_a,
   input  logic [SLICE_W*WORDS-1:0]   op_b,
`ifdef CHAIN_EN
   input  logic                       chain_in,
`endif
   input  logic                       carry_in,
   output logic                       result_valid,
   input  logic                       result_ready,
   output logic [SLICE_W*WORDS-1:0]   sum,
   output logic                       carry_out,
   output logic                       overflow,
   output logic                       busy
);

   localparam int unsigned W     = SLICE_W * WORDS;
   localparam int unsigned IDX_W = idx_width(WORDS);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic [W-1:0]       a_q, b_q;

   logic               accept;
   logic               last_slice;
   logic               init_carry;
   logic [SLICE_W-1:0] cla_a, cla_b, cla_s;
   logic               cla_co;

   assign accept     = start_valid && (state_q == IDLE);
   assign last_slice = (idx_q == IDX_W'(WORDS - 1));

`ifdef CHAIN_EN
   logic last_carry_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_carry_q <= 1'b0;
      end else if (state_q == DONE && result_ready) begin
         last_carry_q <= cout_q;
      end
   end

   assign init_carry = chain_in ? last_carry_q : carry_in;
`else
   assign init_carry = carry_in;
`endif

   assign cla_a = a_q[SLICE_W*32'(idx_q) +: SLICE_W];
   assign cla_b = b_q[SLICE_W*32'(idx_q) +: SLICE_W];

   carry_look_ahead_adder u_cla (
      .a_i         (cla_a),
      .b_i         (cla_b),
      .carry_in_i  (carry_q),
      .s_o         (cla_s),
      .carry_out_o (cla_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               state_d = RUN;
               idx_d   = '0;
               sum_d   = '0;
               carry_d = init_carry;
            end
         end
         RUN: begin
            sum_d[SLICE_W*32'(idx_q) +: SLICE_W] = cla_s;
            carry_d = cla_co;
            idx_d   = idx_q + 1'b1;
            if (last_slice) begin
               cout_d  = cla_co;
               // Signed overflow: like-signed operands producing an opposite-signed top bit.
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_s[SLICE_W-1] != a_q[W-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: operand copies are pure datapath, always written before use, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= op_a;
         b_q <= op_b;
      end
   end

   assign start_ready  = (state_q == IDLE);
   assign busy         = (state_q == RUN);
   assign result_valid = (state_q == DONE);
   assign sum          = sum_q;
   assign carry_out    = cout_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_multiword_cla_sequencer.sv
// Directed bench for multiword_cla_sequencer (WORDS = 4); chain tests run when CHAIN_EN is defined.
module tb_multiword_cla_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         carry_in;
   logic         result_valid;
   logic         result_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;
   logic         busy;
`ifdef CHAIN_EN
   logic         chain_in;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiword_cla_sequencer #(.WORDS(WORDS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .op_a         (op_a),
      .op_b         (op_b),
`ifdef CHAIN_EN
      .chain_in     (chain_in),
`endif
      .carry_in     (carry_in),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .sum          (sum),
      .carry_out    (carry_out),
      .overflow     (overflow),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present operands for one accept edge, then scramble the inputs.
   task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      op_a        = a;
      op_b        = b;
      carry_in    = cin;
      start_valid = 1'b1;
      check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
      @(negedge clk);
      start_valid = 1'b0;
      op_a        = $urandom;
      op_b        = $urandom;
      carry_in    = 1'($urandom);
   endtask

   // Called on the first RUN cycle; counts cycles until result_valid.
   task automatic wait_result(input string tag);
      int n      = 0;
      int busy_n = 0;
      while (!result_valid && n < 50) begin
         if (busy) busy_n++;
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(WORDS));
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(WORDS));
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] s, input logic co, input logic ov);
      check({tag, "_sum"}, 64'(sum), 64'(s));
      check({tag, "_carry_out"}, 64'(carry_out), 64'(co));
      check({tag, "_overflow"}, 64'(overflow), 64'(ov));
   endtask

   task automatic consume(input string tag);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check({tag, "_rv_dropped"}, 64'(result_valid), 64'd0);
      check({tag, "_idle_ready"}, 64'(start_ready), 64'd1);
   endtask

   initial begin
      rst_n        = 1'b0;
      start_valid  = 1'b0;
      op_a         = '0;
      op_b         = '0;
      carry_in     = 1'b0;
      result_ready = 1'b0;
`ifdef CHAIN_EN
      chain_in     = 1'b0;
`endif
      @(negedge clk);
      check("rst_start_ready", 64'(start_ready), 64'd1);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_carry_out", 64'(carry_out), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add with latency and busy-length checks.
      issue("t1", 32'h0000_00A6, 32'h0000_00A6, 1'b0);
      wait_result("t1");
      check_result("t1", 32'h0000_014C, 1'b0, 1'b0);

      // Result held under backpressure; new request must wait.
      start_valid = 1'b1;
      op_a        = 32'h0000_0001;
      op_b        = 32'h0000_0002;
      carry_in    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_sum_held", 64'(sum), 64'h14C);
         check("bp_start_ready", 64'(start_ready), 64'd0);
         check("bp_result_valid", 64'(result_valid), 64'd1);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("bp_rv_dropped", 64'(result_valid), 64'd0);
      check("bp_idle_ready", 64'(start_ready), 64'd1);
      @(negedge clk);
      start_valid = 1'b0;
      wait_result("bp");
      check_result("bp", 32'h0000_0003, 1'b0, 1'b0);
      consume("bp");

      // Unsigned wrap and signed overflow.
      issue("t2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_result("t2a");
      check_result("t2a", 32'h0000_0000, 1'b1, 1'b0);
      consume("t2a");
      issue("t2b", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_result("t2b");
      check_result("t2b", 32'h8000_0000, 1'b0, 1'b1);
      consume("t2b");

      // Reset asserted on the second RUN cycle abandons the add.
      issue("t4", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      @(negedge clk);
      check("t4_mid_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t4_rst_sum", 64'(sum), 64'd0);
      check("t4_rst_result_valid", 64'(result_valid), 64'd0);
      check("t4_rst_busy", 64'(busy), 64'd0);
      check("t4_rst_start_ready", 64'(start_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);
      issue("t4r", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      wait_result("t4r");
      check_result("t4r", 32'h0000_0000, 1'b1, 1'b0);
      consume("t4r");

      // Back-to-back transactions at the minimum period.
      issue("t5a", 32'h1020_3040, 32'h0102_0304, 1'b0);
      wait_result("t5a");
      check_result("t5a", 32'h1122_3344, 1'b0, 1'b0);
      consume("t5a");
      issue("t5b", 32'h0000_00FF, 32'h0000_0001, 1'b1);
      wait_result("t5b");
      check_result("t5b", 32'h0000_0101, 1'b0, 1'b0);
      consume("t5b");

`ifdef CHAIN_EN
      // Carry from one transaction seeds the next when chain_in is set.
      chain_in = 1'b0;
      issue("t6a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_result("t6a");
      check_result("t6a", 32'h0000_0000, 1'b1, 1'b0);
      consume("t6a");
      chain_in = 1'b1;
      issue("t6b", 32'h0000_0000, 32'h0000_0000, 1'b0);
      chain_in = 1'b0;
      wait_result("t6b");
      check_result("t6b", 32'h0000_0001, 1'b0, 1'b0);
      consume("t6b");
      issue("t6c", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_result("t6c");
      consume("t6c");
      chain_in = 1'b0;
      issue("t6d", 32'h0000_0000, 32'h0000_0000, 1'b0);
      wait_result("t6d");
      check_result("t6d", 32'h0000_0000, 1'b0, 1'b0);
      consume("t6d");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
